// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing fed from a small power-of-two byte FIFO.
// Frames start only while uart_tx_en is high; a frame in flight always completes.
module uart_tx #(
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_tx_en,
  input  logic                          uart_tx_valid,
  input  logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
  localparam int unsigned CntW         = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
  localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW       = PtrW + 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(CyclesPerBit - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);
  localparam logic              StopLast  = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              ready_q;
  logic              push, pop;

  // Serializer state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;
  logic            bit_end, can_start;

  // Ready is registered, so a full FIFO never accepts even when a pop happens that cycle.
  assign push = uart_tx_valid & ready_q & ~rst;

  // Occupancy next-state from push/pop
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CountFull);
    end
  end

  // FIFO data array; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_tx_data;
  end

  assign bit_end   = (cnt_q == CntLast);
  assign can_start = (count_q != '0) && uart_tx_en;

  // Frame sequencing; txd_d is the line value for the cycle after the edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          state_d = StStart;
          cnt_d   = '0;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          txd_d     = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d    = StStop;
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shreg_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_idx_q == StopLast) begin
            // Chain straight into the next start bit when data is waiting
            if (can_start) begin
              pop     = 1'b1;
              shreg_d = mem_q[rd_ptr_q];
              state_d = StStart;
              txd_d   = 1'b0;
            end else begin
              state_d = StIdle;
              txd_d   = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Serializer registers; reset aborts any frame and forces the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shreg_q    <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd      = txd_q;
  assign uart_tx_busy  = (state_q != StIdle);
  assign uart_tx_ready = ready_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, directed frame sequences and a random run,
// all checked against a frame-timer reference model.
module tb_uart_tx;

  localparam int ClkHz    = 50_000_000;
  localparam int BitRate  = 5_000_000;
  localparam int StopBits = 1;
  localparam int Depth    = 4;
  localparam int Cpb      = ClkHz / BitRate;
  localparam int FrameLen = Cpb * (9 + StopBits);

  logic       clk, rst, en, valid;
  logic [7:0] data;
  logic       ready, txd, busy;
  logic [2:0] count;

  uart_tx #(
    .BIT_RATE  (BitRate),
    .CLK_HZ    (ClkHz),
    .STOP_BITS (StopBits),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_tx_en   (en),
    .uart_tx_valid(valid),
    .uart_tx_data (data),
    .uart_tx_ready(ready),
    .uart_txd     (txd),
    .uart_tx_busy (busy),
    .fifo_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: queued bytes plus cycles left in the frame on the line
  int         m_timer;
  logic [7:0] m_byte;
  logic [7:0] m_q[$];

  logic txd_log[$];
  logic busy_log[$];

  typedef struct {
    logic       rst, en, valid;
    logic [7:0] data;
    logic       txd, busy, ready;
    logic [2:0] count;
  } vec_t;
  vec_t tbl[8];

  function automatic logic model_txd();
    int p, b;
    if (m_timer == 0) return 1'b1;
    p = FrameLen - m_timer;
    b = p / Cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
    logic do_push, do_pop;
    rst = r; en = e; valid = v; data = d;
    @(posedge clk);
    if (r) begin
      m_timer = 0;
      m_q.delete();
    end else begin
      do_push = v && (m_q.size() != Depth);
      do_pop  = e && (m_q.size() != 0) && (m_timer <= 1);
      if (do_pop) begin
        m_byte  = m_q.pop_front();
        m_timer = FrameLen;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (do_push) m_q.push_back(d);
    end
    #1;
    check("model", {26'd0, txd, busy, ready, count},
          {26'd0, model_txd(), m_timer != 0, m_q.size() != Depth, 3'(m_q.size())});
    txd_log.push_back(txd);
    busy_log.push_back(busy);
  endtask

  task automatic log_clear();
    txd_log.delete();
    busy_log.delete();
  endtask

  function automatic int first_busy();
    for (int i = 0; i < busy_log.size(); i++) if (busy_log[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int s);
    int n = 0;
    if (s < 0) return 0;
    for (int i = s; i < busy_log.size() && busy_log[i]; i++) n++;
    return n;
  endfunction

  // Receiver view: sample each data bit mid-period from a frame starting at s
  function automatic logic [7:0] decode(input int s);
    logic [7:0] b = 8'h00;
    int idx;
    if (s < 0) return 8'hxx;
    for (int k = 0; k < 8; k++) begin
      idx = s + Cpb * (k + 1) + Cpb / 2;
      if (idx < txd_log.size()) b[k] = txd_log[idx];
      else b[k] = 1'bx;
    end
    return b;
  endfunction

  initial begin
    int s, errs, cnt_busy, cnt_low, vprob, eprob;
    logic [7:0] a5;
    logic exp_bit;
    n_vec = 0; n_err = 0;
    m_timer = 0; m_byte = 8'h00;
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = 8'h00;

    // Reset with valid held high, then five pushes into a four-deep FIFO with en low
    tbl[0] = '{rst:1, en:0, valid:1, data:8'h77, txd:1, busy:0, ready:1, count:3'd0};
    tbl[1] = '{rst:1, en:0, valid:1, data:8'h78, txd:1, busy:0, ready:1, count:3'd0};
    tbl[2] = '{rst:0, en:0, valid:1, data:8'h01, txd:1, busy:0, ready:1, count:3'd1};
    tbl[3] = '{rst:0, en:0, valid:1, data:8'h02, txd:1, busy:0, ready:1, count:3'd2};
    tbl[4] = '{rst:0, en:0, valid:1, data:8'h03, txd:1, busy:0, ready:1, count:3'd3};
    tbl[5] = '{rst:0, en:0, valid:1, data:8'h04, txd:1, busy:0, ready:0, count:3'd4};
    tbl[6] = '{rst:0, en:0, valid:1, data:8'h05, txd:1, busy:0, ready:0, count:3'd4};
    tbl[7] = '{rst:0, en:0, valid:0, data:8'h00, txd:1, busy:0, ready:0, count:3'd4};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].data);
      check($sformatf("table[%0d]", i), {26'd0, txd, busy, ready, count},
            {26'd0, tbl[i].txd, tbl[i].busy, tbl[i].ready, tbl[i].count});
    end

    // Back-to-back drain of the four buffered bytes
    log_clear();
    repeat (420) step(1'b0, 1'b1, 1'b0, 8'h00);
    s = first_busy();
    check("b2b_start", s, 0);
    check("b2b_busy_run", run_len(s), 400);
    for (int f = 0; f < 4; f++) check($sformatf("b2b_byte%0d", f), decode(s + f * FrameLen), f + 1);
    check("b2b_empty", {29'd0, ready, count}, {29'd0, 1'b1, 3'd0});

    // Single byte 0xA5, cycle-exact line shape
    log_clear();
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    repeat (110) step(1'b0, 1'b1, 1'b0, 8'h00);
    s = first_busy();
    check("a5_latency", s, 1);
    check("a5_busy_len", run_len(s), 100);
    a5 = 8'hA5;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 10) exp_bit = 1'b0;
      else if (i < 90) exp_bit = a5[i / 10 - 1];
      else exp_bit = 1'b1;
      if (s >= 0 && txd_log[s + i] !== exp_bit) errs++;
    end
    check("a5_line_errs", errs, 0);
    check("a5_rx", decode(s), 8'hA5);

    // Enable dropped during DATA of the first of two bytes
    step(1'b0, 1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'hC3);
    log_clear();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (30) step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (150) step(1'b0, 1'b0, 1'b0, 8'h00);
    s = first_busy();
    check("endrop_rx", decode(s), 8'h5A);
    check("endrop_len", run_len(s), 100);
    check("endrop_hold", {29'd0, busy, count}, {29'd0, 1'b0, 3'd1});
    log_clear();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("endrop_resume", {29'd0, busy, count}, {29'd0, 1'b1, 3'd0});
    repeat (105) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("endrop_rx2", decode(0), 8'hC3);

    // Reset during data bit 3 of 0x3C with two more bytes queued
    step(1'b0, 1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (44) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("mid_bit3", {31'd0, txd}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("rst_abort", {26'd0, txd, busy, ready, count}, {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
    log_clear();
    repeat (150) step(1'b0, 1'b1, 1'b0, 8'h00);
    cnt_busy = 0; cnt_low = 0;
    for (int i = 0; i < busy_log.size(); i++) begin
      if (busy_log[i]) cnt_busy++;
      if (!txd_log[i]) cnt_low++;
    end
    check("rst_quiet_busy", cnt_busy, 0);
    check("rst_quiet_line", cnt_low, 0);

    // Random traffic in segments of varying push rate and enable duty
    vprob = 2; eprob = 90;
    for (int i = 0; i < 6000; i++) begin
      if (i % 300 == 0) begin
        vprob = (i % 900 == 0) ? 30 : ((i % 600 == 0) ? 1 : 4);
        eprob = (i % 1200 == 0) ? 40 : 95;
      end
      step(($urandom_range(0, 799) == 0),
           ($urandom_range(0, 99) < eprob),
           ($urandom_range(0, 99) < vprob),
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
